freq_meter_1s_gate: RTL and testbench

//  Frequency meter: counts rising edges of a slow async input sig_in over a

---
 rtl/freq_meter_1s_gate.sv | 157 +++++++++++++++
 tb/tb_freq_meter_1s_gate.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/freq_meter_1s_gate.sv
// freq_meter_1s_gate
//   Counts rising edges of the slow asynchronous input sig_in over a gate
//   window of exactly K clk_in cycles. With K = 100e6 at 100 MHz the result
//   reads directly in Hz. Gates run back-to-back while meas_en is held high,
//   with no dead cycle between windows.
//
//   State table
//     IDLE | counters cleared, waiting for meas_en
//     GATE | window open, edges being counted; busy=1
//
// Ports
//   clk_in     in   1  reference clock
//   rst        in   1  asynchronous reset, active high
//   sig_in     in   1  measured signal, asynchronous to clk_in
//   meas_en    in   1  1 = run gates continuously, 0 = stop/abort
//   freq_out   out  W  edge count of the last completed gate
//   freq_valid out  1  one-cycle pulse when freq_out/overflow update
//   overflow   out  1  last completed gate saturated the count
//   busy       out  1  1 while in GATE
module freq_meter_1s_gate #(
  parameter int K = 100000000,
  parameter int M = 27,
  parameter int W = 27
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         sig_in,
  input  logic         meas_en,
  output logic [W-1:0] freq_out,
  output logic         freq_valid,
  output logic         overflow,
  output logic         busy
);

  typedef enum logic {IDLE, GATE} state_t;

  localparam logic [M-1:0] GATE_LAST = M'(K);
  localparam logic [M-1:0] GATE_ONE  = M'(1);
  localparam logic [W-1:0] CNT_ONE   = W'(1);
  localparam logic [W-1:0] CNT_MAX   = '1;

  state_t       state, state_next;
  logic [M-1:0] gate_cnt, gate_cnt_next;
  logic [W-1:0] edge_cnt, edge_cnt_next;
  logic         ovf_flag, ovf_flag_next;
  logic [W-1:0] freq_out_next;
  logic         overflow_next;
  logic         freq_valid_next;

  logic         s1, s2, s3;
  logic         edge_pulse;
  logic [W-1:0] cnt_sum;
  logic         cnt_ovf;

  // three-flop synchroniser; s1/s2 resolve metastability, s3 gives the
  // previous level for edge detection
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_pulse = s2 & ~s3;

  // Saturating add of the current edge. Overflow means an edge arrived
  // while the count was already pinned at its maximum, i.e. an edge was lost.
  always_comb begin
    cnt_ovf = edge_pulse & (edge_cnt == CNT_MAX);
    cnt_sum = edge_cnt;
    if (edge_pulse && !cnt_ovf) begin
      cnt_sum = edge_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      ovf_flag   <= 1'b0;
      freq_out   <= '0;
      overflow   <= 1'b0;
      freq_valid <= 1'b0;
    end else begin
      state      <= state_next;
      gate_cnt   <= gate_cnt_next;
      edge_cnt   <= edge_cnt_next;
      ovf_flag   <= ovf_flag_next;
      freq_out   <= freq_out_next;
      overflow   <= overflow_next;
      freq_valid <= freq_valid_next;
    end
  end

  always_comb begin
    state_next      = state;
    gate_cnt_next   = gate_cnt;
    edge_cnt_next   = edge_cnt;
    ovf_flag_next   = ovf_flag;
    freq_out_next   = freq_out;
    overflow_next   = overflow;
    freq_valid_next = 1'b0;

    unique case (state)
      IDLE: begin
        gate_cnt_next = '0;
        edge_cnt_next = '0;
        ovf_flag_next = 1'b0;
        if (meas_en) begin
          state_next    = GATE;
          gate_cnt_next = GATE_ONE;
        end
      end

      GATE: begin
        if (gate_cnt == GATE_LAST) begin
          // last window cycle: the edge seen now still belongs to this gate,
          // and the result completes even if meas_en has just dropped
          freq_out_next   = cnt_sum;
          overflow_next   = ovf_flag | cnt_ovf;
          freq_valid_next = 1'b1;
          edge_cnt_next   = '0;
          ovf_flag_next   = 1'b0;
          if (meas_en) begin
            gate_cnt_next = GATE_ONE;
          end else begin
            state_next    = IDLE;
            gate_cnt_next = '0;
          end
        end else if (!meas_en) begin
          // abort: partial count discarded, last result held
          state_next    = IDLE;
          gate_cnt_next = '0;
          edge_cnt_next = '0;
          ovf_flag_next = 1'b0;
        end else begin
          edge_cnt_next = cnt_sum;
          ovf_flag_next = ovf_flag | cnt_ovf;
          gate_cnt_next = gate_cnt + GATE_ONE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state == GATE);

endmodule

// File: tb/tb_freq_meter_1s_gate.sv
// Bench for freq_meter_1s_gate. Two instances with K=100 share all stimulus:
// dut_a with W=8 and dut_b with W=5 (so a 50-edge gate saturates in dut_b
// only). Stimulus pushes the hand-computed result of each gate that will
// complete; per-instance monitors pop and compare on every freq_valid.
module tb_freq_meter_1s_gate;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       sig_in = 1'b0;
  logic       meas_en = 1'b0;
  logic [7:0] freq_a;
  logic       valid_a, ovf_a, busy_a;
  logic [4:0] freq_b;
  logic       valid_b, ovf_b, busy_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int cyc;
    int freq;
    bit ovf;
    bit busy;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  // per-gate edge counts of the mixed-pattern session (W=8 view)
  int tbl_s1[11] = '{10, 10, 0, 1, 0, 50, 10, 1, 0, 1, 10};

  freq_meter_1s_gate #(.K(100), .M(7), .W(8)) dut_a (
    .clk_in(clk_in), .rst(rst), .sig_in(sig_in), .meas_en(meas_en),
    .freq_out(freq_a), .freq_valid(valid_a), .overflow(ovf_a), .busy(busy_a)
  );

  freq_meter_1s_gate #(.K(100), .M(7), .W(5)) dut_b (
    .clk_in(clk_in), .rst(rst), .sig_in(sig_in), .meas_en(meas_en),
    .freq_out(freq_b), .freq_valid(valid_b), .overflow(ovf_b), .busy(busy_b)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Value driven for relative slot rel. A value driven in slot r is counted
  // (if it is a rise) in gate r/100, so each 100-slot block maps to one gate.
  function automatic bit pat(input int sel, input int rel);
    int g, o;
    if (rel < 0) return 1'b0;
    g = rel / 100;
    o = rel % 100;
    if (sel == 2) return (rel % 10) < 5;
    case (g)
      2, 8:    return 1'b0;
      3:       return o >= 50;
      4:       return o < 99;
      5:       return (o % 2) == 0;
      7:       return o == 99;
      9:       return o == 0;
      default: return (o % 10) < 5;
    endcase
  endfunction

  task automatic run_session(input int sel, input int n_done, input int stop_rel,
                             input bit stop_by_rst);
    int   e0, rel, g;
    exp_t ea, eb;
    e0 = cyc + 4;
    for (int i = 0; i < stop_rel + 12; i++) begin
      @(negedge clk_in);
      rel = cyc - (e0 - 2);
      sig_in = pat(sel, rel);
      if (rel == 1) begin
        meas_en = 1'b1;
        rst = 1'b0;
      end
      if (rel >= 0 && rel % 100 == 0 && rel / 100 < n_done) begin
        g = rel / 100;
        ea.cyc  = e0 + 100 * (g + 1);
        ea.freq = (sel == 1) ? tbl_s1[g] : 10;
        ea.ovf  = 1'b0;
        ea.busy = (stop_rel != 100 * (g + 1) + 1);
        eb = ea;
        if (sel == 1 && g == 5) begin
          eb.freq = 31;
          eb.ovf  = 1'b1;
        end
        q_a.push_back(ea);
        q_b.push_back(eb);
      end
      if (rel == stop_rel) begin
        if (stop_by_rst) begin
          rst = 1'b1;
          #1;
          check("rst_mid_freq_a", int'(freq_a), 0);
          check("rst_mid_freq_b", int'(freq_b), 0);
          check("rst_mid_valid_a", int'(valid_a), 0);
          check("rst_mid_busy_a", int'(busy_a), 0);
          check("rst_mid_busy_b", int'(busy_b), 0);
          check("rst_mid_ovf_b", int'(ovf_b), 0);
        end else begin
          meas_en = 1'b0;
        end
      end
    end
  endtask

  always @(negedge clk_in) begin
    exp_t e;
    if (valid_a) begin
      if (q_a.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL a_unexpected_valid: got pulse expected none (cycle %0d)", cyc);
      end else begin
        e = q_a.pop_front();
        check("a_freq", int'(freq_a), e.freq);
        check("a_ovf", int'(ovf_a), int'(e.ovf));
        check("a_busy", int'(busy_a), int'(e.busy));
        check("a_valid_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk_in) begin
    exp_t e;
    if (valid_b) begin
      if (q_b.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_unexpected_valid: got pulse expected none (cycle %0d)", cyc);
      end else begin
        e = q_b.pop_front();
        check("b_freq", int'(freq_b), e.freq);
        check("b_ovf", int'(ovf_b), int'(e.ovf));
        check("b_busy", int'(busy_b), int'(e.busy));
        check("b_valid_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk_in);
    check("reset_freq_a", int'(freq_a), 0);
    check("reset_valid_a", int'(valid_a), 0);
    check("reset_ovf_a", int'(ovf_a), 0);
    check("reset_busy_a", int'(busy_a), 0);
    check("reset_freq_b", int'(freq_b), 0);
    check("reset_busy_b", int'(busy_b), 0);

    // mixed patterns over 11 completed gates, abort at cycle 50 of gate 11
    run_session(1, 11, 1151, 1'b0);
    check("abort_freq_a", int'(freq_a), 10);
    check("abort_freq_b", int'(freq_b), 10);
    check("abort_ovf_b", int'(ovf_b), 0);
    check("abort_busy_a", int'(busy_a), 0);
    check("abort_busy_b", int'(busy_b), 0);

    // re-raise: one gate, then reset at gate_cnt=60 of the second gate
    run_session(2, 1, 161, 1'b1);

    // restart out of reset: two gates, meas_en dropped on the last cycle
    run_session(2, 2, 201, 1'b0);
    repeat (150) @(negedge clk_in);
    check("end_busy_a", int'(busy_a), 0);
    check("end_freq_a", int'(freq_a), 10);
    check("end_freq_b", int'(freq_b), 10);
    check("missing_valid_a", q_a.size(), 0);
    check("missing_valid_b", q_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
